// File: rtl/ram_arbiter.sv
// Two-port RAM arbiter: fetch (read-only) vs data load/store, with a data-side lock.
// Define RAM_ARB_RR_EN for round-robin priority in ARB; otherwise data wins conflicts.
module ram_arbiter #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [DW-1:0] f_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic          d_lock,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          ram_rd_en,
   output logic [AW-1:0] ram_rd_adress,
   output logic          ram_write_en,
   output logic [AW-1:0] ram_write_adress,
   output logic [DW-1:0] ram_data_in,
   input  logic [DW-1:0] ram_data_out
);

   typedef enum logic {ARB, LOCK_D} state_t;

   state_t state, state_nxt;
   logic   f_win, d_win;

`ifdef RAM_ARB_RR_EN
   logic last_f;  // 1 = fetch port was granted most recently
`endif

   // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
   always_comb begin
      f_win = 1'b0;
      d_win = 1'b0;
      if (!rst) begin
         if (state == LOCK_D) begin
            d_win = d_req;
         end else if (f_req && d_req) begin
`ifdef RAM_ARB_RR_EN
            d_win = last_f;
            f_win = !last_f;
`else
            d_win = 1'b1;
`endif
         end else begin
            f_win = f_req;
            d_win = d_req;
         end
      end
   end

   assign f_gnt = f_win;
   assign d_gnt = d_win;

   always_comb begin
      ram_rd_en        = 1'b0;
      ram_rd_adress    = '0;
      ram_write_en     = 1'b0;
      ram_write_adress = '0;
      ram_data_in      = '0;
      if (f_win) begin
         ram_rd_en     = 1'b1;
         ram_rd_adress = f_addr;
      end else if (d_win) begin
         if (d_we) begin
            ram_write_en     = 1'b1;
            ram_write_adress = d_addr;
            ram_data_in      = d_wdata;
         end else begin
            ram_rd_en     = 1'b1;
            ram_rd_adress = d_addr;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ARB:     if (d_win && d_lock) state_nxt = LOCK_D;
         LOCK_D:  if (!d_lock)         state_nxt = ARB;
         default: state_nxt = ARB;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ARB;
         f_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
      end else begin
         state    <= state_nxt;
         f_rvalid <= f_win;
         d_rvalid <= d_win && !d_we;
      end
   end

`ifdef RAM_ARB_RR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        last_f <= 1'b1;
      else if (f_win) last_f <= 1'b1;
      else if (d_win) last_f <= 1'b0;
   end
`endif

   // The RAM has one read port; each requester qualifies the shared data with its rvalid.
   assign f_rdata = ram_data_out;
   assign d_rdata = ram_data_out;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, reset corner cases,
// and randomized traffic against a behavioural model (honours RAM_ARB_RR_EN).
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       f_req, d_req, d_we, d_lock;
   logic [7:0] f_addr, d_addr, d_wdata;
   logic       f_gnt, f_rvalid, d_gnt, d_rvalid;
   logic [7:0] f_rdata, d_rdata;
   logic       ram_rd_en, ram_write_en;
   logic [7:0] ram_rd_adress, ram_write_adress, ram_data_in, ram_data_out;

   int checks   = 0;
   int failures = 0;

   logic [7:0] mem    [256];
   logic [7:0] shadow [256];

   always #5 clk = ~clk;

   ram_arbiter #(.AW(8), .DW(8)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .ram_rd_en(ram_rd_en), .ram_rd_adress(ram_rd_adress),
      .ram_write_en(ram_write_en), .ram_write_adress(ram_write_adress),
      .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
   );

   // Synchronous RAM with one-cycle read latency
   always @(posedge clk) begin
      if (ram_write_en) mem[ram_write_adress] <= ram_data_in;
      if (ram_rd_en)    ram_data_out <= mem[ram_rd_adress];
   end

   typedef struct {
      logic       fr;
      logic [7:0] fa;
      logic       dr, dw, dl;
      logic [7:0] da, dwd;
      logic       efg, edg, efrv, edrv;
      logic [7:0] erd;
   } vec_t;

   vec_t pre[$];
   vec_t plan[$];

   function automatic vec_t mk(logic fr, logic [7:0] fa, logic dr, logic dw, logic dl,
                               logic [7:0] da, logic [7:0] dwd, logic efg, logic edg,
                               logic efrv, logic edrv, logic [7:0] erd);
      vec_t v;
      v.fr = fr; v.fa = fa; v.dr = dr; v.dw = dw; v.dl = dl; v.da = da; v.dwd = dwd;
      v.efg = efg; v.edg = edg; v.efrv = efrv; v.edrv = edrv; v.erd = erd;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic fr, input logic [7:0] fa, input logic dr, input logic dw,
                        input logic dl, input logic [7:0] da, input logic [7:0] dwd);
      f_req = fr; f_addr = fa; d_req = dr; d_we = dw; d_lock = dl; d_addr = da; d_wdata = dwd;
   endtask

   task automatic check_ram(input string tag, input logic efg, input logic edg);
      logic erd_en, ewr_en;
      erd_en = efg || (edg && !d_we);
      ewr_en = edg && d_we;
      check({tag, "_fgnt"}, f_gnt, efg);
      check({tag, "_dgnt"}, d_gnt, edg);
      check({tag, "_rd_en"}, ram_rd_en, erd_en);
      check({tag, "_wr_en"}, ram_write_en, ewr_en);
      if (efg) check({tag, "_rd_adr"}, ram_rd_adress, f_addr);
      else if (erd_en) check({tag, "_rd_adr"}, ram_rd_adress, d_addr);
      if (ewr_en) begin
         check({tag, "_wr_adr"}, ram_write_adress, d_addr);
         check({tag, "_wr_dat"}, ram_data_in, d_wdata);
      end
      if (!efg && !edg) begin
         check({tag, "_idle_rd_adr"}, ram_rd_adress, 0);
         check({tag, "_idle_wr_adr"}, ram_write_adress, 0);
         check({tag, "_idle_dat"}, ram_data_in, 0);
      end
   endtask

   task automatic run_table(input string tag, input vec_t tbl[$]);
      for (int i = 0; i < tbl.size(); i++) begin
         string nm;
         nm = $sformatf("%s%0d", tag, i);
         drive(tbl[i].fr, tbl[i].fa, tbl[i].dr, tbl[i].dw, tbl[i].dl, tbl[i].da, tbl[i].dwd);
         @(negedge clk);
         check_ram(nm, tbl[i].efg, tbl[i].edg);
         check({nm, "_frv"}, f_rvalid, tbl[i].efrv);
         check({nm, "_drv"}, d_rvalid, tbl[i].edrv);
         if (tbl[i].efrv) check({nm, "_frdata"}, f_rdata, tbl[i].erd);
         if (tbl[i].edrv) check({nm, "_drdata"}, d_rdata, tbl[i].erd);
         @(posedge clk); #1;
      end
   endtask

   task automatic reset_pulse();
      drive(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Behavioural model state for the random phase
   bit         m_lock, m_last_f, m_frv, m_drv;
   logic [7:0] m_fdata, m_ddata;

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state with both ports requesting
      rst = 1'b1;
      drive(1, 8'h10, 1, 1, 1, 8'h20, 8'hEE);
      @(negedge clk);
      check("rst_fgnt", f_gnt, 0);
      check("rst_dgnt", d_gnt, 0);
      check("rst_rd_en", ram_rd_en, 0);
      check("rst_wr_en", ram_write_en, 0);
      check("rst_frv", f_rvalid, 0);
      check("rst_drv", d_rvalid, 0);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;

      // Preload RAM through the data port
      pre.push_back(mk(0, 0, 1, 1, 0, 8'h10, 8'hA5, 0, 1, 0, 0, 0));
      pre.push_back(mk(0, 0, 1, 1, 0, 8'h11, 8'h99, 0, 1, 0, 0, 0));
      pre.push_back(mk(0, 0, 1, 1, 0, 8'h20, 8'h11, 0, 1, 0, 0, 0));
      pre.push_back(mk(0, 0, 1, 1, 0, 8'h21, 8'h22, 0, 1, 0, 0, 0));
      pre.push_back(mk(0, 0, 1, 1, 0, 8'h30, 8'h77, 0, 1, 0, 0, 0));
      pre.push_back(mk(0, 0, 1, 1, 0, 8'h31, 8'h88, 0, 1, 0, 0, 0));
      pre.push_back(mk(0, 0, 1, 1, 0, 8'h50, 8'h55, 0, 1, 0, 0, 0));
      pre.push_back(mk(0, 0, 1, 1, 0, 8'h60, 8'h66, 0, 1, 0, 0, 0));
      run_table("pre", pre);
      reset_pulse();

      // Conflict: both held 4 cycles
`ifdef RAM_ARB_RR_EN
      plan.push_back(mk(1, 8'h30, 1, 0, 0, 8'h31, 0, 0, 1, 0, 0, 0));
      plan.push_back(mk(1, 8'h30, 1, 0, 0, 8'h31, 0, 1, 0, 0, 1, 8'h88));
      plan.push_back(mk(1, 8'h30, 1, 0, 0, 8'h31, 0, 0, 1, 1, 0, 8'h77));
      plan.push_back(mk(1, 8'h30, 1, 0, 0, 8'h31, 0, 1, 0, 0, 1, 8'h88));
      plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h77));
`else
      plan.push_back(mk(1, 8'h30, 1, 0, 0, 8'h31, 0, 0, 1, 0, 0, 0));
      plan.push_back(mk(1, 8'h30, 1, 0, 0, 8'h31, 0, 0, 1, 0, 1, 8'h88));
      plan.push_back(mk(1, 8'h30, 1, 0, 0, 8'h31, 0, 0, 1, 0, 1, 8'h88));
      plan.push_back(mk(1, 8'h30, 1, 0, 0, 8'h31, 0, 0, 1, 0, 1, 8'h88));
      plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h88));
`endif
      // Data write then read
      plan.push_back(mk(0, 0, 1, 1, 0, 8'h40, 8'h3C, 0, 1, 0, 0, 0));
      plan.push_back(mk(0, 0, 1, 0, 0, 8'h40, 0, 0, 1, 0, 0, 0));
      plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h3C));
      // Single fetch
      plan.push_back(mk(1, 8'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'hA5));
      // Locked sequence with fetch held high
      plan.push_back(mk(1, 8'h50, 1, 0, 1, 8'h20, 0, 0, 1, 0, 0, 0));
      plan.push_back(mk(1, 8'h50, 1, 0, 1, 8'h21, 0, 0, 1, 0, 1, 8'h11));
      plan.push_back(mk(1, 8'h50, 1, 1, 0, 8'h22, 8'h5A, 0, 1, 0, 1, 8'h22));
      plan.push_back(mk(1, 8'h50, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h55));
      // d_lock without d_req in ARB has no effect
      plan.push_back(mk(1, 8'h10, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
      plan.push_back(mk(1, 8'h11, 0, 0, 0, 0, 0, 1, 0, 1, 0, 8'hA5));
      plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h99));
      // LOCK_D holds with d_req=0; exit takes effect after the d_lock=0 cycle
      plan.push_back(mk(0, 0, 1, 0, 1, 8'h60, 0, 0, 1, 0, 0, 0));
      plan.push_back(mk(1, 8'h10, 0, 0, 1, 0, 0, 0, 0, 0, 1, 8'h66));
      plan.push_back(mk(1, 8'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      plan.push_back(mk(1, 8'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'hA5));
      // Locked write landed
      plan.push_back(mk(0, 0, 1, 0, 0, 8'h22, 0, 0, 1, 0, 0, 0));
      plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h5A));
      run_table("plan", plan);

      // Reset mid-lock, in the cycle after a locked D read grant
      drive(0, 0, 1, 0, 1, 8'h20, 0);
      @(negedge clk);
      check("ml_dgnt", d_gnt, 1);
      @(posedge clk); #1;
      drive(1, 8'h10, 1, 0, 1, 8'h21, 0);
      rst = 1'b1;
      #1;
      check("ml_async_drv", d_rvalid, 0);
      @(negedge clk);
      check("ml_fgnt", f_gnt, 0);
      check("ml_dgnt_rst", d_gnt, 0);
      check("ml_rd_en", ram_rd_en, 0);
      check("ml_wr_en", ram_write_en, 0);
      check("ml_drv", d_rvalid, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1, 8'h10, 0, 0, 0, 0, 0);
      @(negedge clk);
      check_ram("ml_after", 1, 0);
      check("ml_after_drv", d_rvalid, 0);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("ml_after_frv", f_rvalid, 1);
      check("ml_after_frdata", f_rdata, 8'hA5);
      @(posedge clk); #1;

      // Randomized traffic against the behavioural model
      reset_pulse();
      for (int a = 0; a < 256; a++) shadow[a] = mem[a];
      m_lock = 0; m_last_f = 1; m_frv = 0; m_drv = 0; m_fdata = 0; m_ddata = 0;
      begin
         bit f_pend, d_pend;
         f_pend = 0; d_pend = 0;
         for (int c = 0; c < 3000; c++) begin
            bit eg_f, eg_d;
            if (!f_pend) begin
               f_req  = ($urandom_range(0, 99) < 60);
               f_addr = 8'($urandom);
            end
            if (!d_pend) begin
               d_req   = ($urandom_range(0, 99) < 60);
               d_we    = 1'($urandom);
               d_lock  = ($urandom_range(0, 99) < 30);
               d_addr  = 8'($urandom);
               d_wdata = 8'($urandom);
            end
            @(negedge clk);
            // Owner rules: a locked data port excludes fetch; otherwise priority decides conflicts
            eg_f = f_req && !m_lock;
            eg_d = d_req;
            if (eg_f && eg_d) begin
`ifdef RAM_ARB_RR_EN
               if (m_last_f) eg_f = 0;
               else          eg_d = 0;
`else
               eg_f = 0;
`endif
            end
            check_ram("rnd", eg_f, eg_d);
            check("rnd_frv", f_rvalid, m_frv);
            check("rnd_drv", d_rvalid, m_drv);
            if (m_frv) check("rnd_frdata", f_rdata, m_fdata);
            if (m_drv) check("rnd_drdata", d_rdata, m_ddata);
            m_frv = eg_f;
            m_drv = eg_d && !d_we;
            if (eg_f) m_fdata = shadow[f_addr];
            if (eg_d && !d_we) m_ddata = shadow[d_addr];
            if (eg_d && d_we) shadow[d_addr] = d_wdata;
            if (!m_lock) m_lock = eg_d && d_lock;
            else         m_lock = d_lock;
            if (eg_f) m_last_f = 1;
            else if (eg_d) m_last_f = 0;
            f_pend = f_req && !eg_f;
            d_pend = d_req && !eg_d;
            @(posedge clk); #1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the processor's single RAM between the instruction-fetch path (PC-addressed, read-only) and a data load/store path. It sits between the control unit, the fetch path, and the `ram` instance. It grants at most one RAM access per cycle and returns read-valid strobes aligned to the RAM's one-cycle read latency. A data-side lock gives the data port exclusive ownership for multi-byte sequences.

## Interface
- AW, 8, address width
- DW, 8, data width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- f_req  in  1  fetch read request
- f_addr  in  AW  fetch address
- f_gnt  out  1  fetch granted this cycle (combinational)
- f_rvalid  out  1  f_rdata valid (registered)
- f_rdata  out  DW  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_lock  in  1  keep data-port ownership after this access
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_gnt  out  1  data granted this cycle (combinational)
- d_rvalid  out  1  d_rdata valid (registered)
- d_rdata  out  DW  data read data
- ram_rd_en  out  1  to ram rd_en
- ram_rd_adress  out  AW  to ram rd_adress
- ram_write_en  out  1  to ram write_en
- ram_write_adress  out  AW  to ram write_adress
- ram_data_in  out  DW  to ram data_in
- ram_data_out  in  DW  from ram data_out, valid 1 cycle after rd_en

## Operation
- Requester protocol:
  - A requester holds req, addr, we and wdata stable until it sees gnt high.
  - A transaction completes in the cycle gnt is high.
  - Keeping req high with new address/data in the following cycle gives back-to-back accesses at one per cycle.
- Grant logic:
  - Grant is combinational from the current req inputs plus registered state.
  - f_gnt and d_gnt are never high together.
- RAM drive:
  - Granted read: ram_rd_en=1 and ram_rd_adress = the winner's address.
  - Granted write (D only): ram_write_en=1, ram_write_adress=d_addr, ram_data_in=d_wdata.
  - No grant: all RAM strobes are 0. Address and data outputs are 0.
- Read return:
  - f_rdata and d_rdata are wired directly to ram_data_out.
  - Each is meaningful only while its rvalid is high.
- FSM states:
  - ARB: normal arbitration.
  - LOCK_D: data port owns the RAM; f_gnt is forced to 0.
- FSM transitions:
  - ARB -> LOCK_D when d_gnt=1 and d_lock=1.
  - LOCK_D -> ARB at the end of any cycle with d_lock=0. A D access granted in that same cycle is still performed.
  - In LOCK_D with d_lock=1 and d_req=0, the state holds and the RAM is idle.
- Priority when both request in ARB: fixed, D wins. F stalls until d_req drops.
- A single request in ARB is always granted immediately. The arbiter adds no bubbles.

## Timing
- Grant latency: 0 cycles, same cycle as req.
- Read latency: rvalid goes high exactly 1 cycle after a granted read, for 1 cycle. Back-to-back reads give continuous rvalid.
- Writes produce no rvalid.
- Reset values:
  - state = ARB.
  - f_rvalid = d_rvalid = 0.
  - Round-robin pointer = "last granted F".
  - While rst is high, f_gnt, d_gnt and all RAM strobes are 0.
- Reset mid-lock returns to ARB. Reset also drops any rvalid pending from the previous cycle.
- Boundary cases:
  - Address wrap 8'hFF -> 8'h00 is the requester's concern. The arbiter passes addresses unmodified.
  - d_lock asserted with d_req=0 in ARB has no effect, because lock is only entered on a grant.

## Configuration
- RAM_ARB_RR_EN defined: round-robin priority in ARB.
  - A 1-bit pointer records the last port granted.
  - On conflict, the port not granted last wins.
  - The pointer updates on every grant, including grants made in LOCK_D (those record D).
- RAM_ARB_RR_EN undefined:
  - Fixed D-over-F priority.
  - No pointer register is built.

## Test plan
- Single fetch: f_req=1, f_addr=8'h10 for 1 cycle, RAM[8'h10]=8'hA5 -> f_gnt=1, ram_rd_en=1 with address 8'h10; next cycle f_rvalid=1, f_rdata=8'hA5; d_rvalid stays 0.
- Data write then read: d_req=1, d_we=1, d_addr=8'h40, d_wdata=8'h3C; then d_we=0 on the same address -> ram_write_en pulses 1 cycle; the read gives d_rvalid=1 with d_rdata=8'h3C one cycle after its grant.
- Conflict:
  - f_req and d_req held 4 cycles with different addresses.
  - Without macro: d_gnt=1 every cycle and f_gnt=0.
  - With RAM_ARB_RR_EN: grants alternate D, F, D, F.
- Lock: D reads 8'h20 with d_lock=1, then reads 8'h21 with d_lock=1, then writes 8'h22 with d_lock=0, while f_req is held high -> f_gnt=0 for all three cycles; f_gnt=1 in the next cycle.
- Reset mid-lock: enter LOCK_D, then assert rst for 1 cycle in the cycle after a D read grant -> d_rvalid=0, all strobes 0 during rst; after release, a lone f_req is granted immediately.
